// File: rtl/aes_round_sequencer.sv
// AES block sequencer: walks one block through initial key add, full rounds and final round,
// fetching each round key from the key-schedule memory and handing the result out over valid/ready.
module aes_round_sequencer #(
  parameter int regSize    = 32,
  parameter int vecSize    = 4,
  parameter int NUM_ROUNDS = 10,
  localparam int RW        = $clog2(NUM_ROUNDS + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_valid,
  output logic                              start_ready,
  input  logic [vecSize-1:0][regSize-1:0]   plaintext,
  output logic                              rk_rd_en,
  output logic [RW-1:0]                     rk_addr,
  input  logic [vecSize-1:0][regSize-1:0]   rk_rd_data,
  output logic [vecSize-1:0][regSize-1:0]   dp_state,
  output logic [vecSize-1:0][regSize-1:0]   dp_round_key,
  output logic [1:0]                        dp_mode,
  input  logic [vecSize-1:0][regSize-1:0]   dp_result,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [vecSize-1:0][regSize-1:0]   ciphertext,
  output logic [RW-1:0]                     round_idx
);

  typedef enum logic [2:0] {IDLE, KEY_REQ, KEY_WAIT, APPLY, DONE} fsm_t;

  localparam logic [1:0] MODE_ARK   = 2'b00;
  localparam logic [1:0] MODE_FULL  = 2'b01;
  localparam logic [1:0] MODE_FINAL = 2'b10;

  fsm_t                            fsm_q, fsm_d;
  logic [vecSize-1:0][regSize-1:0] state_q, key_q;
  logic [RW-1:0]                   round_q;
  logic                            last_round;

  assign last_round = (round_q == RW'(NUM_ROUNDS));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      case (fsm_q)
        IDLE: if (start_valid) begin
          state_q <= plaintext;
          round_q <= '0;
        end
        KEY_WAIT: key_q <= rk_rd_data;
        APPLY: begin
          state_q <= dp_result;
          // counter saturates at the final round; DONE/IDLE reload it on the next start
          if (!last_round) round_q <= round_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    start_ready = 1'b0;
    rk_rd_en    = 1'b0;
    dp_mode     = MODE_ARK;
    out_valid   = 1'b0;
    ciphertext  = '0;
    case (fsm_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) fsm_d = KEY_REQ;
      end
      KEY_REQ: begin
        rk_rd_en = 1'b1;
        fsm_d    = KEY_WAIT;
      end
      KEY_WAIT: fsm_d = APPLY;
      APPLY: begin
        if (round_q == '0)   dp_mode = MODE_ARK;
        else if (last_round) dp_mode = MODE_FINAL;
        else                 dp_mode = MODE_FULL;
        fsm_d = last_round ? DONE : KEY_REQ;
      end
      DONE: begin
        out_valid  = 1'b1;
        ciphertext = state_q;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // datapath always sees the held state/key; only APPLY commits its result
  assign dp_state     = state_q;
  assign dp_round_key = key_q;
  assign rk_addr      = round_q;
  assign round_idx    = round_q;

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Sequences one AES block encryption through the external round-transform datapath. The datapath combines the SubBytes, ShiftRows, MixColumns and AddRoundKey stages.
- Fetches each round key from the key-schedule memory, applies the rounds in order, holds the state between rounds, and returns the ciphertext over a valid/ready handshake.
- Sits between the SIMD vector register file / issue logic and the AES datapath.
- The state and key vectors use the same column packing as the add_round_key stage.

Parameters:
- regSize, 32, width of one state column (bits).
- vecSize, 4, number of columns per state/key vector.
- NUM_ROUNDS, 10, number of full and final rounds after the initial key add (legal range 1..14).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start_valid  in  1  plaintext offered.
- start_ready  out  1  sequencer can accept a block.
- plaintext  in  [vecSize-1:0][regSize-1:0]  input state; element [i] = column i.
- rk_rd_en  out  1  round-key memory read strobe.
- rk_addr  out  $clog2(NUM_ROUNDS+1)  round-key index.
- rk_rd_data  in  [vecSize-1:0][regSize-1:0]  key columns; valid exactly 1 cycle after rk_rd_en.
- dp_state  out  [vecSize-1:0][regSize-1:0]  state presented to datapath.
- dp_round_key  out  [vecSize-1:0][regSize-1:0]  key presented to datapath.
- dp_mode  out  2  00 = AddRoundKey only, 01 = full round, 10 = final round (no MixColumns), 11 unused.
- dp_result  in  [vecSize-1:0][regSize-1:0]  combinational datapath output.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts ciphertext.
- ciphertext  out  [vecSize-1:0][regSize-1:0]  result state.
- round_idx  out  $clog2(NUM_ROUNDS+1)  current round (debug/status).

Behaviour:

Reset (rst_n=0 at a rising edge):
- FSM goes to IDLE; state_q, key_q, round counter = 0.
- Outputs: start_ready=1, rk_rd_en=0, rk_addr=0, dp_mode=00, out_valid=0, ciphertext=0, round_idx=0.
- Reset mid-block aborts the block with no output.

FSM states:
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready: state_q<=plaintext, round<=0, go to KEY_REQ.
- KEY_REQ:
  - rk_rd_en=1, rk_addr=round.
  - Go to KEY_WAIT.
- KEY_WAIT:
  - key_q<=rk_rd_data.
  - Go to APPLY.
- APPLY:
  - dp_state=state_q, dp_round_key=key_q.
  - dp_mode = 00 if round==0, 10 if round==NUM_ROUNDS, else 01.
  - state_q<=dp_result.
  - If round==NUM_ROUNDS, go to DONE; else round<=round+1 and go to KEY_REQ.
- DONE:
  - out_valid=1, ciphertext=state_q.
  - Hold until out_ready; on out_valid&&out_ready go to IDLE.

Output and handshake rules:
- start_ready=1 only in IDLE. start_valid in any other state is ignored; plaintext is not sampled.
- Latency: out_valid asserts exactly 3*(NUM_ROUNDS+1) rising edges after the accepting edge (33 for the default).
- Throughput: one block in flight. A new start is accepted no earlier than the cycle after the out handshake, so there is no same-cycle IDLE bypass.
- ciphertext is stable while out_valid=1 and out_ready=0; out_valid is never dropped without a handshake.
- rk_rd_data is sampled only in KEY_WAIT; it is don't-care elsewhere.
- Outside APPLY: dp_mode=00, dp_state=state_q, dp_round_key=key_q. Datapath output is ignored.
- round_idx=round in all states.
- round counter never exceeds NUM_ROUNDS; there is no wrap.

Test Plan:
- Bench setup: datapath model XORs state with key for every mode. NUM_ROUNDS=1; key[0]=AABBCCDD,EEFF0011,22334455,66778899; key[1]=0.
  - Scenario 1 (single block): plaintext columns 00112233,44556677,8899AABB,CCDDEEFF.
    - -> ciphertext AAAAEEEE,AAAA6666,AAAAEEEE,AAAA6666.
    - -> out_valid exactly 6 edges after accept.
    - -> dp_mode sequence 00 then 10.
- Scenario 2 (default NUM_ROUNDS=10, key[i] all columns = i):
  - -> rk_addr visits 0..10 in order, one rk_rd_en pulse per round.
  - -> dp_mode 00, nine × 01, then 10.
  - -> out_valid at edge 33.
  - -> ciphertext = plaintext ^ {4{0^1^...^10 = 0000000B}}.
- Scenario 3 (start while busy): assert start_valid with a different plaintext during rounds 2–5.
  - -> start_ready=0 throughout; result unaffected; second block accepted only after the out handshake.
- Scenario 4 (output backpressure): out_ready=0 for 7 cycles, then 1.
  - -> out_valid and ciphertext held constant for 7 cycles.
  - -> IDLE and start_ready=1 on the cycle after the handshake.
- Scenario 5 (reset mid-operation): rst_n=0 for one edge during KEY_WAIT of round 4.
  - -> next cycle: IDLE, out_valid=0, round_idx=0, rk_rd_en=0.
  - -> a fresh block then completes with the correct result.
- Scenario 6 (stale key data): rk_rd_data driven to FFFFFFFF in all cycles except KEY_WAIT.
  - -> ciphertext identical to Scenario 1/2 results.
